// File: rtl/bias_act_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bias_act_if                                                   |
// | Brief    : Output beat stream of bias_act: one channel per beat with      |
// |            valid/ready handshake.                                        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface bias_act_if #(
    parameter int PIX = 12,
    parameter int W   = 16
);
    logic               out_valid;
    logic               out_ready;
    logic [PIX*W-1:0]   q;
    logic [4:0]         ch_idx;
    logic               last;

    modport master (output out_valid, q, ch_idx, last, input out_ready);
    modport slave  (input out_valid, q, ch_idx, last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/bias_act.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bias_act                                                      |
// | Brief    : Captures a CHxPIX dot result, adds a per-layer/channel bias,   |
// |            applies ReLU and streams one channel per beat.                 |
// |            Optional BIAS_ACT_SAT_EN: saturate the sum instead of wrapping.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd0
`define LAYER1 4'd1
`define LAYER2 4'd2
`define LAYER3 4'd3
`define AFFINE 4'd4
`endif

module bias_act #(
    parameter int CH  = 32,
    parameter int PIX = 12,
    parameter int W   = `DATA_LEN
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [3:0]            cs_layer,
    input  wire logic                  in_valid,
    input  wire logic [CH*PIX*W-1:0]   d,
    input  wire logic                  bias_we,
    input  wire logic [7:0]            bias_addr,
    input  wire logic [W-1:0]          bias_wdata,
    bias_act_if.master                 m_out,
    output logic                       busy,
    output logic                       overrun
);

    localparam int          C_BIAS_DEPTH = 160;
    localparam logic [4:0]  C_LAST_CH    = 5'(CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CAPT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_in_valid_q;
    logic                   r_valid;
    logic [PIX*W-1:0]       r_q;
    logic [4:0]             r_ch;
    logic                   r_last;
    logic                   r_overrun;
    logic [CH*PIX*W-1:0]    r_buf;
    logic [3:0]             r_layer;
    logic [W-1:0]           r_bias [0:C_BIAS_DEPTH-1];

    logic                   w_rise;
    logic [4:0]             w_next_ch;
    logic [2:0]             w_lidx;
    logic                   w_bias_ok;
    logic                   w_relu;
    logic [7:0]             w_baddr;
    logic [W-1:0]           w_bias;
    logic [PIX*W-1:0]       w_beat;

    assign w_rise    = in_valid & ~r_in_valid_q;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;
    // Channel whose beat gets loaded at the next edge: 0 from CAPT, else the successor.
    assign w_next_ch = (r_state == S_CAPT) ? 5'd0 : r_ch + 5'd1;

    always_comb begin
        w_lidx    = 3'd0;
        w_bias_ok = 1'b1;
        w_relu    = 1'b1;
        case (r_layer)
            `LAYER0: w_lidx = 3'd0;
            `LAYER1: w_lidx = 3'd1;
            `LAYER2: w_lidx = 3'd2;
            `LAYER3: w_lidx = 3'd3;
            `AFFINE: begin
                w_lidx = 3'd4;
                w_relu = 1'b0;
            end
            default: begin
                w_bias_ok = 1'b0;
                w_relu    = 1'b0;
            end
        endcase
    end

    assign w_baddr = {w_lidx, w_next_ch};
    assign w_bias  = w_bias_ok ? r_bias[w_baddr] : '0;

    always_comb begin : comb_beat
        logic [W-1:0] v_elem;
        logic [W-1:0] v_res;
`ifdef BIAS_ACT_SAT_EN
        logic [W:0]   v_sum;
        v_sum  = '0;
`endif
        v_elem = '0;
        v_res  = '0;
        w_beat = '0;
        for (int p = 0; p < PIX; p++) begin
            v_elem = r_buf[(PIX*int'(w_next_ch) + p)*W +: W];
`ifdef BIAS_ACT_SAT_EN
            v_sum = {v_elem[W-1], v_elem} + {w_bias[W-1], w_bias};
            if (v_sum[W] != v_sum[W-1])
                v_res = v_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else
                v_res = v_sum[W-1:0];
`else
            v_res = v_elem + w_bias;
`endif
            if (w_relu && v_res[W-1])
                v_res = '0;
            w_beat[p*W +: W] = v_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_valid_q <= 1'b0;
            r_valid      <= 1'b0;
            r_q          <= '0;
            r_ch         <= 5'd0;
            r_last       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_in_valid_q <= in_valid;
            if (w_rise && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rise)
                        r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_valid <= 1'b1;
                    r_q     <= w_beat;
                    r_ch    <= 5'd0;
                    r_last  <= (CH == 1);
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (r_valid && m_out.out_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_q    <= w_beat;
                            r_ch   <= w_next_ch;
                            r_last <= (w_next_ch == C_LAST_CH);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data buffer and bias table carry no reset; the table survives rst.
    always_ff @(posedge clk) begin
        if (w_rise && r_state == S_IDLE) begin
            r_buf   <= d;
            r_layer <= cs_layer;
        end
        if (bias_we && !busy && bias_addr < 8'(C_BIAS_DEPTH))
            r_bias[bias_addr] <= bias_wdata;
    end

    assign m_out.out_valid = r_valid;
    assign m_out.q         = r_q;
    assign m_out.ch_idx    = r_ch;
    assign m_out.last      = r_last;

endmodule
`default_nettype wire

// File: tb/tb_bias_act.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized scoreboard bench for bias_act: a rule-level model predicts every beat.
`ifndef LAYER0
`define LAYER0 4'd0
`define LAYER1 4'd1
`define LAYER2 4'd2
`define LAYER3 4'd3
`define AFFINE 4'd4
`endif

module tb_bias_act;
    localparam int CH  = 32;
    localparam int PIX = 12;
    localparam int W   = 16;
    localparam int DW  = CH*PIX*W;
    localparam logic [3:0] L0 = `LAYER0;
    localparam logic [3:0] L1 = `LAYER1;
    localparam logic [3:0] L2 = `LAYER2;
    localparam logic [3:0] L3 = `LAYER3;
    localparam logic [3:0] LA = `AFFINE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      cs_layer = '0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   d = '0;
    logic            bias_we = 1'b0;
    logic [7:0]      bias_addr = '0;
    logic [W-1:0]    bias_wdata = '0;
    logic            busy;
    logic            overrun;

    bias_act_if #(.PIX(PIX), .W(W)) u_if();

    bias_act #(.CH(CH), .PIX(PIX), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_layer   (cs_layer),
        .in_valid   (in_valid),
        .d          (d),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .bias_wdata (bias_wdata),
        .m_out      (u_if),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PIX*W-1:0] q;
        int               ch;
        bit               last;
    } beat_t;

    beat_t            sb[$];
    beat_t            mon_exp;
    int               checks = 0;
    int               errors = 0;
    int               mb [0:159];
    logic [PIX*W-1:0] beat_log [0:CH-1];
    int               beats_seen = 0;
    int               rdy_mode = 0;
    bit               stall_pending = 0;
    logic [PIX*W-1:0] stall_q;
    logic [4:0]       stall_ch;
    logic             stall_last;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: signed add, then wrap or clamp to W bits, then ReLU on the layers that use it.
    function automatic logic [W-1:0] model_elem(input logic [W-1:0] e, input logic [3:0] layer, input int ch);
        int s, b, idx;
        bit relu;
        logic [W-1:0] t;
        idx = -1;
        relu = 1'b1;
        if (layer == L0) idx = 0;
        else if (layer == L1) idx = 1;
        else if (layer == L2) idx = 2;
        else if (layer == L3) idx = 3;
        else if (layer == LA) begin idx = 4; relu = 1'b0; end
        else relu = 1'b0;
        b = (idx >= 0) ? mb[idx*32 + ch] : 0;
        s = int'($signed(e)) + b;
`ifdef BIAS_ACT_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`else
        t = s[W-1:0];
        s = int'($signed(t));
`endif
        if (relu && s < 0) s = 0;
        t = s[W-1:0];
        return t;
    endfunction

    function automatic logic [DW-1:0] rand_d();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_xfer(input logic [3:0] layer, input logic [DW-1:0] dv);
        beat_t b;
        for (int c = 0; c < CH; c++) begin
            for (int p = 0; p < PIX; p++)
                b.q[p*W +: W] = model_elem(dv[(PIX*c + p)*W +: W], layer, c);
            b.ch = c;
            b.last = (c == CH-1);
            sb.push_back(b);
        end
    endtask

    task automatic bias_write(input int addr, input int val, input bit honour);
        logic [W-1:0] t;
        t = val[W-1:0];
        bias_we = 1'b1;
        bias_addr = addr[7:0];
        bias_wdata = t;
        if (honour && addr < 160) mb[addr] = int'($signed(t));
        @(posedge clk); #1;
        bias_we = 1'b0;
    endtask

    task automatic start_xfer(input logic [3:0] layer, input logic [DW-1:0] dv, input bit hold);
        @(posedge clk); #1;
        cs_layer = layer;
        d = dv;
        in_valid = 1'b1;
        push_xfer(layer, dv);
        if (!hold) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            d = rand_d();
            cs_layer = 4'($urandom);
        end
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !u_if.out_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 256'(ok), 256'(1));
    endtask

    task automatic wait_beats(input int target);
        for (int i = 0; i < 400; i++) begin
            if (beats_seen >= target) break;
            @(posedge clk); #1;
        end
        chk("beat_progress", 256'(beats_seen >= target), 256'(1));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        u_if.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       u_if.out_ready = 1'b1;
                1:       u_if.out_ready = ~u_if.out_ready;
                default: u_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                checks++;
                if (!(u_if.out_valid && u_if.q === stall_q && u_if.ch_idx === stall_ch && u_if.last === stall_last)) begin
                    errors++;
                    $display("FAIL stall_hold actual ch=%0d q=%0h required ch=%0d q=%0h", u_if.ch_idx, u_if.q, stall_ch, stall_q);
                end
            end
            stall_pending = u_if.out_valid && !u_if.out_ready;
            stall_q = u_if.q;
            stall_ch = u_if.ch_idx;
            stall_last = u_if.last;
            if (u_if.out_valid && u_if.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual ch=%0d required none", u_if.ch_idx);
                end else begin
                    mon_exp = sb.pop_front();
                    if (u_if.q !== mon_exp.q || int'(u_if.ch_idx) != mon_exp.ch || u_if.last !== mon_exp.last) begin
                        errors++;
                        $display("FAIL beat actual ch=%0d last=%0b q=%0h required ch=%0d last=%0b q=%0h",
                                 u_if.ch_idx, u_if.last, u_if.q, mon_exp.ch, mon_exp.last, mon_exp.q);
                    end
                end
                beat_log[u_if.ch_idx] = u_if.q;
                beats_seen++;
            end
        end
    end

    initial begin
        logic [DW-1:0] dv;
        int lat, base;
        logic [3:0] layers [6];
        layers[0] = L0; layers[1] = L1; layers[2] = L2;
        layers[3] = L3; layers[4] = LA; layers[5] = 4'd9;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 256'(u_if.out_valid), 256'(0));
        chk("reset_q", 256'(u_if.q), 256'(0));
        chk("reset_ch_last", {u_if.ch_idx, u_if.last}, 256'(0));
        chk("reset_busy_overrun", {busy, overrun}, 256'(0));
        rst = 1'b0;

        for (int a = 0; a < 160; a++) bias_write(a, 0, 1'b1);
        bias_write(200, 16'h5555, 1'b0);

        // Ramp data, zero bias, in_valid held high across and after the transfer
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < PIX; p++) dv[(PIX*c + p)*W +: W] = W'(c*16 + p);
        start_xfer(L0, dv, 1'b1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (u_if.out_valid) break;
        end
        chk("first_valid_latency", 256'(lat), 256'(2));
        wait_done("ramp_done");
        repeat (5) @(posedge clk);
        #1;
        chk("held_no_retrigger", {u_if.out_valid, overrun}, 256'(0));
        in_valid = 1'b0;
        chk("ramp_ch5_p3", 256'(beat_log[5][3*W +: W]), 256'(16'd83));
        chk("ramp_ch31_p11", 256'(beat_log[31][11*W +: W]), 256'(16'd507));

        // Negative bias: AFFINE keeps the sign, LAYER1 clamps through ReLU
        bias_write(128 + 3, -10, 1'b1);
        bias_write(35, -10, 1'b1);
        dv = rand_d();
        for (int p = 0; p < PIX; p++) dv[(PIX*3 + p)*W +: W] = 16'd5;
        start_xfer(LA, dv, 1'b0);
        wait_done("affine_done");
        chk("affine_ch3_p0", 256'(beat_log[3][0 +: W]), 256'(16'hFFFB));
        chk("affine_ch3_p11", 256'(beat_log[3][11*W +: W]), 256'(16'hFFFB));
        start_xfer(L1, dv, 1'b0);
        wait_done("layer1_done");
        chk("layer1_ch3_p0", 256'(beat_log[3][0 +: W]), 256'(0));

        // Overflowing sum on channel 0
        bias_write(0, 16'h0100, 1'b1);
        dv = rand_d();
        for (int p = 0; p < PIX; p++) dv[p*W +: W] = 16'h7FF0;
        start_xfer(L0, dv, 1'b0);
        wait_done("overflow_done");
`ifdef BIAS_ACT_SAT_EN
        chk("overflow_ch0", 256'(beat_log[0][0 +: W]), 256'(16'h7FFF));
`else
        chk("overflow_ch0", 256'(beat_log[0][0 +: W]), 256'(16'h0000));
`endif

        // Alternating out_ready
        for (int c = 0; c < CH; c++) bias_write(64 + c, int'($urandom_range(0, 65535)), 1'b1);
        rdy_mode = 1;
        base = beats_seen;
        start_xfer(L2, rand_d(), 1'b0);
        wait_done("toggle_done");
        chk("toggle_beat_count", 256'(beats_seen - base), 256'(32));

        // Random layers, data, biases and backpressure
        rdy_mode = 2;
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 10; k++)
                bias_write(int'($urandom_range(0, 159)), int'($urandom_range(0, 65535)), 1'b1);
            start_xfer(layers[$urandom_range(0, 5)], rand_d(), 1'b0);
            wait_done("random_done");
        end

        // Rising edge coinciding with acceptance of the final beat
        rdy_mode = 0;
        do_reset();
        start_xfer(L3, rand_d(), 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (u_if.out_valid && u_if.last) break;
        end
        chk("final_beat_seen", 256'(u_if.out_valid && u_if.last), 256'(1));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_edge_ignored", {u_if.out_valid, busy, overrun}, 256'(1));
        wait_done("final_edge_done");

        // Second pulse mid-stream, bias write while busy, reset mid-stream
        do_reset();
        base = beats_seen;
        start_xfer(L2, rand_d(), 1'b0);
        wait_beats(base + 10);
        in_valid = 1'b1;
        d = rand_d();
        bias_write(64 + 25, 16'h1234, 1'b0);
        in_valid = 1'b0;
        wait_beats(base + 20);
        chk("overrun_set", 256'(overrun), 256'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("after_rst", {u_if.out_valid, overrun, busy}, 256'(0));
        base = beats_seen;
        repeat (10) @(posedge clk);
        #1;
        chk("no_beats_after_rst", 256'(beats_seen - base), 256'(0));
        start_xfer(L2, rand_d(), 1'b0);
        wait_done("post_rst_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bias_act.md
BIAS_ACT -- requirements
Module: bias_act

Interface
REQ-001 Parameter: CH, 32, output channels per dot result.
REQ-002 Parameter: PIX, 12, pixel lanes per channel.
REQ-003 Parameter: W, `data_len, element width in bits, signed two's complement.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cs_layer  in  4  layer select (`LAYER0..`LAYER3, `AFFINE); sampled at capture.
REQ-007 in_valid  in  1  dot result valid (level; may stay high many cycles).
REQ-008 d  in  CH*PIX*W  dot result; element (ch c, pixel p) at bits [(PIX*c+p)*W +: W].
REQ-009 bias_we  in  1  bias table write strobe.
REQ-010 bias_addr  in  8  bias index = layer_idx*32 + ch (layer_idx 0..4 = LAYER0..3, AFFINE).
REQ-011 bias_wdata  in  W  bias value.
REQ-012 out_ready  in  1  downstream accepts beat.
REQ-013 out_valid  out  1  beat on q is valid.
REQ-014 q  out  PIX*W  one channel, pixel p at [p*W +: W].
REQ-015 ch_idx  out  5  channel of current beat.
REQ-016 last  out  1  high with ch_idx==CH-1 beat.
REQ-017 busy  out  1  high in CAPT or STREAM.
REQ-018 overrun  out  1  sticky: new result arrived while busy.

Function
REQ-019 FSM states IDLE, CAPT, STREAM; IDLE->CAPT on in_valid rising edge (in_valid & ~in_valid_q); CAPT->STREAM next cycle; STREAM->IDLE when beat ch 31 accepted.
REQ-020 On rising edge in IDLE: latch all of d into CH*PIX buffer and cs_layer into layer register in same cycle.
REQ-021 In CAPT: compute beat ch 0 into q register; out_valid asserts the cycle after CAPT (2 cycles after in_valid rises).
REQ-022 Beat accepted when out_valid & out_ready; next channel's q, ch_idx, last registered on same edge; zero bubbles under continuous out_ready.
REQ-023 While out_valid & ~out_ready: q, ch_idx, last held stable.
REQ-024 Per element: s = d + bias[layer_idx*32+ch], computed in W+1 bits signed.
REQ-025 ReLU applied (s<0 -> 0) for LAYER0..LAYER3; bypassed for AFFINE.
REQ-026 cs_layer outside the five codes: bias 0, ReLU off.
REQ-027 Rising edge of in_valid while busy: ignored, buffer untouched, overrun set.
REQ-028 in_valid held high after capture does not retrigger; new capture needs low then high.
REQ-029 Bias writes honoured only when busy low; ignored while busy; addr >= 160 ignored.
REQ-030 Simultaneous final acceptance (ch 31) and in_valid rising edge: edge treated as busy -> ignored, overrun set.

Reset
REQ-031 rst high at clock edge: state IDLE, out_valid 0, q 0, ch_idx 0, last 0, busy 0, overrun 0, edge detector 0.
REQ-032 rst mid-stream aborts the transfer; no further beats emitted.
REQ-033 Bias table is not cleared by rst; contents undefined until written.

Configuration
REQ-034 Macro BIAS_ACT_SAT_EN defined: s saturates to [-2^(W-1), 2^(W-1)-1] before ReLU.
REQ-035 Macro BIAS_ACT_SAT_EN undefined: s truncated to low W bits (wrap), then ReLU.

Verification
REQ-036 W=16, bias all 0, LAYER0, d elements = ch*16+p, out_ready=1 -> 32 consecutive beats, q pixel p = ch*16+p, last on ch 31, first out_valid 2 cycles after in_valid rises.
REQ-037 AFFINE, bias[128+3]=-10, d(ch3,*)=5 -> beat ch3 all pixels = -5; same under LAYER1 (bias[35]=-10) -> 0.
REQ-038 SAT_EN, LAYER0, d=0x7FF0, bias=0x0100 -> 0x7FFF; without SAT_EN -> wrapped 0x80F0, ReLU -> 0.
REQ-039 out_ready toggled 1/0 each cycle -> q, ch_idx stable during stall; all 32 beats, none dropped or duplicated.
REQ-040 Second in_valid pulse at beat 10; bias write during stream; rst at beat 20 -> overrun=1, bias unchanged, out_valid=0 and overrun=0 the cycle after rst.
